// File: rtl/pci_master_if.sv
// PCI initiator: requests the bus, runs one address phase and 1..MAX_BURST data phases,
// then releases FRAME#/IRDY#. Master-aborts when no target claims within DEVSEL_TIMEOUT clocks.
module pci_master_if #(
    parameter int MAX_BURST      = 4,
    parameter int DEVSEL_TIMEOUT = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  cmd,
    input  logic [31:0] addr,
    input  logic [2:0]  len,
    input  logic [31:0] wdata,
    output logic [2:0]  data_idx,
    output logic        data_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        abort,
    output logic        req_n,
    input  logic        gnt_n,
    output logic        frame_n,
    output logic        irdy_n,
    input  logic        trdy_n,
    input  logic        devsel_n,
    output logic [31:0] ad_out,
    output logic        ad_oe,
    input  logic [31:0] ad_in,
    output logic [3:0]  cbe_n
);

    localparam int CNT_W = $clog2(DEVSEL_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, REQ, ADDR, DATA, TURN} state_t;

    state_t             state, state_nx;
    logic [3:0]         cmd_q, cmd_nx;
    logic [31:0]        addr_q, addr_nx;
    logic [2:0]         last_q, last_nx;
    logic [CNT_W-1:0]   dcnt_q, dcnt_nx;
    logic               dsel_q, dsel_nx;
    logic [31:0]        ad_out_q, ad_out_nx;

    logic               req_n_nx, frame_n_nx, irdy_n_nx, ad_oe_nx;
    logic [3:0]         cbe_n_nx;
    logic               busy_nx, done_nx, abort_nx, data_ack_nx;
    logic [31:0]        rdata_nx;
    logic [2:0]         data_idx_nx;

    logic               complete, is_last, timeout;

    // Index of the final data phase after applying the 0->1 and MAX_BURST clamps.
    function automatic logic [2:0] last_index(input logic [2:0] l);
        if (l == 3'd0)
            return 3'd0;
        if (int'(l) > MAX_BURST)
            return 3'(MAX_BURST - 1);
        return l - 3'd1;
    endfunction

    assign complete = (state == DATA) && !irdy_n && !trdy_n;
    assign is_last  = (data_idx == last_q);
    assign timeout  = (state == DATA) && !complete && devsel_n && !dsel_q &&
                      (dcnt_q == CNT_W'(DEVSEL_TIMEOUT - 1));

    // Write data is steered straight from local logic while data phases run.
    assign ad_out = (state == DATA && cmd_q[0]) ? wdata : ad_out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cmd_q    <= 4'h0;
            last_q   <= 3'd0;
            dcnt_q   <= '0;
            dsel_q   <= 1'b0;
            ad_out_q <= 32'h0;
            req_n    <= 1'b1;
            frame_n  <= 1'b1;
            irdy_n   <= 1'b1;
            ad_oe    <= 1'b0;
            cbe_n    <= 4'hF;
            busy     <= 1'b0;
            done     <= 1'b0;
            abort    <= 1'b0;
            data_ack <= 1'b0;
            rdata    <= 32'h0;
            data_idx <= 3'd0;
        end else begin
            state    <= state_nx;
            cmd_q    <= cmd_nx;
            last_q   <= last_nx;
            dcnt_q   <= dcnt_nx;
            dsel_q   <= dsel_nx;
            ad_out_q <= ad_out_nx;
            req_n    <= req_n_nx;
            frame_n  <= frame_n_nx;
            irdy_n   <= irdy_n_nx;
            ad_oe    <= ad_oe_nx;
            cbe_n    <= cbe_n_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            abort    <= abort_nx;
            data_ack <= data_ack_nx;
            rdata    <= rdata_nx;
            data_idx <= data_idx_nx;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = REQ;
            REQ:     if (!gnt_n) state_nx = ADDR;
            ADDR:    state_nx = DATA;
            DATA:    if ((complete && is_last) || timeout) state_nx = TURN;
            TURN:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_nx      = cmd_q;
        addr_nx     = addr_q;
        last_nx     = last_q;
        dcnt_nx     = dcnt_q;
        dsel_nx     = dsel_q;
        ad_out_nx   = ad_out_q;
        req_n_nx    = req_n;
        frame_n_nx  = frame_n;
        irdy_n_nx   = irdy_n;
        ad_oe_nx    = ad_oe;
        cbe_n_nx    = cbe_n;
        busy_nx     = busy;
        done_nx     = 1'b0;
        abort_nx    = 1'b0;
        data_ack_nx = 1'b0;
        rdata_nx    = rdata;
        data_idx_nx = data_idx;
        case (state)
            IDLE: begin
                if (start) begin
                    cmd_nx   = cmd;
                    addr_nx  = addr;
                    last_nx  = last_index(len);
                    req_n_nx = 1'b0;
                    busy_nx  = 1'b1;
                end
            end
            REQ: begin
                if (!gnt_n) begin
                    frame_n_nx = 1'b0;
                    ad_oe_nx   = 1'b1;
                    ad_out_nx  = addr_q;
                    cbe_n_nx   = cmd_q;
                    req_n_nx   = 1'b1;
                end
            end
            ADDR: begin
                irdy_n_nx = 1'b0;
                cbe_n_nx  = 4'b0000;
                dcnt_nx   = '0;
                dsel_nx   = 1'b0;
                if (!cmd_q[0])
                    ad_oe_nx = 1'b0;
                if (last_q == 3'd0)
                    frame_n_nx = 1'b1;
            end
            DATA: begin
                if (!devsel_n)
                    dsel_nx = 1'b1;
                if (complete) begin
                    data_ack_nx = 1'b1;
                    data_idx_nx = data_idx + 3'd1;
                    if (!cmd_q[0])
                        rdata_nx = ad_in;
                    if (is_last) begin
                        frame_n_nx = 1'b1;
                        irdy_n_nx  = 1'b1;
                        ad_oe_nx   = 1'b0;
                        cbe_n_nx   = 4'hF;
                        done_nx    = 1'b1;
                    end else if ((data_idx + 3'd1) == last_q) begin
                        frame_n_nx = 1'b1;
                    end
                end else if (timeout) begin
                    frame_n_nx = 1'b1;
                    irdy_n_nx  = 1'b1;
                    ad_oe_nx   = 1'b0;
                    cbe_n_nx   = 4'hF;
                    done_nx    = 1'b1;
                    abort_nx   = 1'b1;
                end else if (devsel_n && !dsel_q) begin
                    dcnt_nx = dcnt_q + 1'b1;
                end
            end
            TURN: begin
                data_idx_nx = 3'd0;
                busy_nx     = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_pci_master_if.sv
// Bench for pci_master_if: acts as arbiter, target and local logic; a monitor
// checks data phases, acks and transaction ends against queued expectations.
module tb_pci_master_if;

    localparam int MAXB = 4;
    localparam int DTO  = 5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  cmd;
    logic [31:0] addr;
    logic [2:0]  len;
    logic [31:0] wdata;
    logic [2:0]  data_idx;
    logic        data_ack;
    logic [31:0] rdata;
    logic        busy, done, abort;
    logic        req_n, gnt_n, frame_n, irdy_n, trdy_n, devsel_n;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic [31:0] ad_in;
    logic [3:0]  cbe_n;
    logic [31:0] wbase;

    int checks = 0;
    int errs   = 0;

    typedef struct {
        logic [2:0]  idx;
        logic [31:0] data;
        bit          rd;
    } ack_t;

    ack_t        aq[$];
    logic [31:0] wq[$];
    bit          dq[$];

    always #5 clk = ~clk;

    // Local logic: write data for phase n is wbase + n.
    assign wdata = wbase + 32'(data_idx);

    pci_master_if #(.MAX_BURST(MAXB), .DEVSEL_TIMEOUT(DTO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cmd(cmd), .addr(addr), .len(len),
        .wdata(wdata), .data_idx(data_idx), .data_ack(data_ack), .rdata(rdata),
        .busy(busy), .done(done), .abort(abort), .req_n(req_n), .gnt_n(gnt_n),
        .frame_n(frame_n), .irdy_n(irdy_n), .trdy_n(trdy_n), .devsel_n(devsel_n),
        .ad_out(ad_out), .ad_oe(ad_oe), .ad_in(ad_in), .cbe_n(cbe_n)
    );

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string nm);
        checks++;
        errs++;
        $display("FAIL %s: got an event, expected none at %0t", nm, $time);
    endtask

    function automatic int eff_len(input logic [2:0] l);
        if (l == 3'd0) return 1;
        if (int'(l) > MAXB) return MAXB;
        return int'(l);
    endfunction

    task automatic rst_checks(input string tag);
        ck({tag, "_req_n"},    32'(req_n),    32'd1);
        ck({tag, "_frame_n"},  32'(frame_n),  32'd1);
        ck({tag, "_irdy_n"},   32'(irdy_n),   32'd1);
        ck({tag, "_ad_oe"},    32'(ad_oe),    32'd0);
        ck({tag, "_ad_out"},   ad_out,        32'd0);
        ck({tag, "_cbe_n"},    32'(cbe_n),    32'hF);
        ck({tag, "_busy"},     32'(busy),     32'd0);
        ck({tag, "_done"},     32'(done),     32'd0);
        ck({tag, "_abort"},    32'(abort),    32'd0);
        ck({tag, "_data_ack"}, 32'(data_ack), 32'd0);
        ck({tag, "_rdata"},    rdata,         32'd0);
        ck({tag, "_data_idx"}, 32'(data_idx), 32'd0);
    endtask

    task automatic finish_now();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
    endtask

    // One transaction. d: data cycles before DEVSEL# claim; wait_ph: phase given one
    // wait state; xs: stray start pulses while busy; rst_ph: reset during that phase.
    task automatic run_txn(input logic [3:0] c, input logic [31:0] a, input logic [2:0] l,
                           input int gdelay, input bit claim, input int d, input int wait_ph,
                           input bit rnd, input bit xs, input int rst_ph,
                           input logic [31:0] wb, input logic [31:0] rb);
        int eff, phase, cyc;
        bit waited, w;
        eff = eff_len(l);
        @(negedge clk);
        wbase = wb; start = 1'b1; cmd = c; addr = a; len = l;
        if (claim) begin
            for (int k = 0; k < eff; k++) begin
                if (rst_ph < 0 || k < rst_ph) begin
                    aq.push_back('{idx: 3'(k + 1), data: rb + 32'(k), rd: !c[0]});
                    if (c[0]) wq.push_back(wb + 32'(k));
                end
            end
        end
        if (rst_ph < 0) dq.push_back(!claim);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i <= gdelay; i++) begin
            ck("req_wait_req_n",   32'(req_n),   32'd0);
            ck("req_wait_frame_n", 32'(frame_n), 32'd1);
            ck("req_wait_busy",    32'(busy),    32'd1);
            start = 1'b0;
            if (i == gdelay) begin
                gnt_n = 1'b0;
            end else begin
                if (xs && i == 0) begin
                    start = 1'b1; cmd = ~c; addr = ~a; len = 3'd1;
                end
                @(negedge clk);
            end
        end
        @(negedge clk);
        ck("addr_frame_n", 32'(frame_n), 32'd0);
        ck("addr_ad_oe",   32'(ad_oe),   32'd1);
        ck("addr_ad_out",  ad_out,       a);
        ck("addr_cbe_n",   32'(cbe_n),   32'(c));
        ck("addr_req_n",   32'(req_n),   32'd1);
        ck("addr_irdy_n",  32'(irdy_n),  32'd1);
        gnt_n = 1'b1; trdy_n = 1'b1; devsel_n = 1'b1;
        phase = 0; cyc = 0; waited = 1'b0;
        if (claim) begin
            while (phase < eff) begin
                @(negedge clk);
                cyc++;
                if (cyc > 200) begin
                    unexpected("data_phase_timeout");
                    finish_now();
                end
                ck("dat_irdy_n",   32'(irdy_n),   32'd0);
                ck("dat_frame_n",  32'(frame_n),  (phase == eff - 1) ? 32'd1 : 32'd0);
                ck("dat_ad_oe",    32'(ad_oe),    32'(c[0]));
                ck("dat_cbe_n",    32'(cbe_n),    32'd0);
                ck("dat_data_idx", 32'(data_idx), 32'(phase));
                ck("dat_busy",     32'(busy),     32'd1);
                devsel_n = (cyc > d) ? 1'b0 : 1'b1;
                ad_in = rb + 32'(phase);
                w = rnd && ($urandom_range(0, 2) == 0);
                if (phase == wait_ph && !waited && !devsel_n) begin
                    w = 1'b1; waited = 1'b1;
                end
                trdy_n = (!devsel_n && !w) ? 1'b0 : 1'b1;
                if (phase == rst_ph) begin
                    trdy_n = 1'b1;
                    #2 rst_n = 1'b0;
                    #1 rst_checks("midrst");
                    @(negedge clk);
                    rst_n = 1'b1; devsel_n = 1'b1; ad_in = 32'h0;
                    return;
                end
                if (!trdy_n) phase++;
            end
        end else begin
            for (int i = 0; i < DTO; i++) begin
                @(negedge clk);
                ck("abt_irdy_n",   32'(irdy_n),   32'd0);
                ck("abt_done",     32'(done),     32'd0);
                ck("abt_frame_n",  32'(frame_n),  (eff == 1) ? 32'd1 : 32'd0);
                ck("abt_data_idx", 32'(data_idx), 32'd0);
            end
        end
        @(negedge clk);
        ck("turn_irdy_n",  32'(irdy_n),  32'd1);
        ck("turn_frame_n", 32'(frame_n), 32'd1);
        ck("turn_ad_oe",   32'(ad_oe),   32'd0);
        ck("turn_cbe_n",   32'(cbe_n),   32'hF);
        ck("turn_busy",    32'(busy),    32'd1);
        ck("turn_req_n",   32'(req_n),   32'd1);
        ck("turn_done",    32'(done),    32'd1);
        ck("turn_abort",   32'(abort),   32'(!claim));
        trdy_n = 1'b1; devsel_n = 1'b1; ad_in = 32'h0;
        if (xs) begin
            start = 1'b1; cmd = c; addr = a; len = l;
        end
        @(negedge clk);
        start = 1'b0;
        ck("idle_busy",     32'(busy),     32'd0);
        ck("idle_req_n",    32'(req_n),    32'd1);
        ck("idle_data_idx", 32'(data_idx), 32'd0);
        ck("idle_done",     32'(done),     32'd0);
    endtask

    // Monitor: write data at each completing phase, acks and transaction ends.
    initial begin
        ack_t        ea;
        logic [31:0] ew;
        bit          eab;
        forever begin
            @(negedge clk);
            #1;
            if (rst_n === 1'b1) begin
                if (!irdy_n && !trdy_n && ad_oe) begin
                    if (wq.size() == 0) begin
                        unexpected("wr_phase_extra");
                    end else begin
                        ew = wq.pop_front();
                        ck("wr_data", ad_out, ew);
                        ck("wr_cbe_n", 32'(cbe_n), 32'd0);
                    end
                end
                if (data_ack) begin
                    if (aq.size() == 0) begin
                        unexpected("data_ack_extra");
                    end else begin
                        ea = aq.pop_front();
                        ck("ack_data_idx", 32'(data_idx), 32'(ea.idx));
                        if (ea.rd) ck("ack_rdata", rdata, ea.data);
                    end
                end
                if (done) begin
                    if (dq.size() == 0) begin
                        unexpected("done_extra");
                    end else begin
                        eab = dq.pop_front();
                        ck("done_abort", 32'(abort), 32'(eab));
                    end
                end
                if (abort && !done) unexpected("abort_without_done");
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; cmd = 4'h0; addr = 32'h0; len = 3'd0;
        gnt_n = 1'b1; trdy_n = 1'b1; devsel_n = 1'b1; ad_in = 32'h0; wbase = 32'h0;
        repeat (3) @(negedge clk);
        rst_checks("por");
        rst_n = 1'b1;

        run_txn(4'b0111, 32'h0000_1000, 3'd1, 2,  1'b1, 1, -1, 1'b0, 1'b0, -1, 32'hCAFE_0000, 32'h0);
        run_txn(4'b0110, 32'h0000_2000, 3'd4, 1,  1'b1, 0,  2, 1'b0, 1'b0, -1, 32'h0,         32'hA0);
        run_txn(4'b0111, 32'h0000_3000, 3'd2, 10, 1'b1, 0, -1, 1'b0, 1'b1, -1, 32'h1234_0000, 32'h0);
        run_txn(4'b0110, 32'h0000_4000, 3'd3, 0,  1'b0, 0, -1, 1'b0, 1'b0, -1, 32'h0,         32'h0);
        run_txn(4'b0111, 32'h0000_5000, 3'd4, 0,  1'b1, 0, -1, 1'b0, 1'b0,  2, 32'h5500_0000, 32'h0);
        run_txn(4'b0111, 32'h0000_5100, 3'd2, 1,  1'b1, 0, -1, 1'b0, 1'b0, -1, 32'h5600_0000, 32'h0);
        run_txn(4'b0111, 32'h0000_6000, 3'd0, 3,  1'b1, 0, -1, 1'b0, 1'b1, -1, 32'h6600_0000, 32'h0);
        run_txn(4'b0110, 32'h0000_7000, 3'd7, 2,  1'b1, 1, -1, 1'b0, 1'b1, -1, 32'h0,         32'h7700_0000);
        run_txn(4'b0111, 32'h0000_8000, 3'd1, 1,  1'b0, 0, -1, 1'b0, 1'b1, -1, 32'h0,         32'h0);

        for (int t = 0; t < 20; t++) begin
            logic [3:0] c;
            bit cl;
            c  = {3'($urandom_range(0, 7)), 1'($urandom_range(0, 1))};
            cl = ($urandom_range(0, 4) != 0);
            run_txn(c, $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 4)), cl,
                    int'($urandom_range(0, 2)), -1, 1'b1, ($urandom_range(0, 1) == 1), -1,
                    $urandom, $urandom);
        end

        repeat (2) @(negedge clk);
        ck("aq_empty", 32'(aq.size()), 32'd0);
        ck("wq_empty", 32'(wq.size()), 32'd0);
        ck("dq_empty", 32'(dq.size()), 32'd0);
        finish_now();
    end

endmodule
